dfr_batch_seq: RTL and testbench
================================

Name: dfr_batch_seq

Overview:
Parametrised successor to the single-stream DFR sequencing FSM. It walks a programmable window of an input sample memory and feeds each {I,Q} word to the DFR compute core over its start/busy/done handshake. Each core result is written to an output RAM. Adds base/length programming, configurable memory read latency, a per-sample core timeout with error reporting, and abort.

Parameters:
ADDR_W, 13, input/output memory address width
DATA_W, 32, input word width; I = upper half, Q = lower half
OUT_W, 26, core result width (sign/exponent/mantissa float)
RD_LAT, 1, input memory read latency in cycles (1..4)
TIMEOUT, 4096, max cycles from core_start to core_done before error

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
cfg_start  in  1  one-cycle pulse; launches a batch when idle, ignored otherwise
cfg_abort  in  1  one-cycle pulse; terminates the batch and returns to idle
cfg_base  in  ADDR_W  first input/output address
cfg_len  in  ADDR_W+1  sample count; 0 completes immediately
sts_busy  out  1  batch in progress
sts_done  out  1  sticky; batch completed normally
sts_error  out  1  sticky; core timeout occurred
sts_count  out  ADDR_W+1  samples completed in current/last batch
in_rd_en  out  1  input memory read strobe
in_addr  out  ADDR_W  input memory address
in_data  in  DATA_W  input memory read data, valid RD_LAT cycles after in_rd_en
core_resetn  out  1  core reset, active low
core_start  out  1  core start
core_busy  in  1  core busy
core_done  in  1  core done pulse
core_i  out  DATA_W/2  I sample to core
core_q  out  DATA_W/2  Q sample to core
core_result  in  OUT_W  core result
out_wen  out  1  output RAM write enable
out_addr  out  ADDR_W  output RAM address (same as the sample's input address)
out_data  out  OUT_W  output RAM write data

Behaviour:
- Reset values: all outputs 0, except core_resetn = 0. State is IDLE.
- States:
  - IDLE: core_resetn = 1. On cfg_start: latch cfg_base/cfg_len, clear sts_done/sts_error/sts_count. Go to DONE if len = 0, else FETCH.
  - FETCH: in_rd_en = 1 for one cycle at base+idx, then go to WAIT_RD.
  - WAIT_RD: count RD_LAT cycles, then register in_data into core_i/core_q and go to CRST.
  - CRST: core_resetn = 0 for one cycle, then go to START.
  - START: core_start = 1 until core_busy is seen high, then go to RUN. If core_done arrives in START, treat it as RUN completion.
  - RUN: wait for core_done, then capture core_result and go to WRITE.
  - WRITE: out_wen = 1 for one cycle, out_addr = base+idx. Increment idx and sts_count. Go to DONE if idx+1 = len, else FETCH.
  - DONE: set sts_done, return to IDLE.
  - ERROR: set sts_error, hold core_resetn = 0 for one cycle, return to IDLE.
- Timeout: a counter starts on entry to START and counts through RUN. When it reaches TIMEOUT, go to ERROR. No write occurs for that sample; sts_count holds the completed-sample count.
- Address wrap: base+idx is modulo 2^ADDR_W, so addresses wrap silently past the top.
- sts_busy = 1 in every state except IDLE.
- cfg_abort: takes priority in any non-IDLE state. Next cycle is IDLE, core_resetn = 0 for one cycle, no out_wen, neither sticky flag set. Abort in IDLE is ignored.
- Simultaneous cfg_start and cfg_abort in IDLE: start wins. A start pulse issued while busy is dropped.
- resetn low mid-batch: all outputs immediately return to their reset values on the next edge.
- Minimum per-sample latency: 1 (FETCH) + RD_LAT + 1 (CRST) + 1 (START) + core time + 1 (WRITE) cycles.

Optional Feature:
Macro DFR_BATCH_SEQ_PERF_EN.
- Defined: adds output sts_cycles [31:0], which counts clk cycles while sts_busy = 1. It is cleared on accepted cfg_start, saturates at all-ones, and is frozen in IDLE.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package dfr_seq_pkg holds:
  - the state enum (IDLE, FETCH, WAIT_RD, CRST, START, RUN, WRITE, DONE, ERROR)
  - the I/Q slice constants derived from DATA_W
  - the default TIMEOUT
- Sub-module dfr_seq_timeout: a loadable down-counter with expire flag, reused for both the RD_LAT wait and the core timeout.

Test Plan:
- base=0, len=3, RD_LAT=1, model core done after 10 cycles:
  - 3 reads at addresses 0,1,2; 3 out_wen at 0,1,2 carrying the model results
  - sts_done=1, sts_count=3, each sample takes 15 cycles
- len=0 start -> sts_done=1 two cycles later; no in_rd_en, no core_start.
- base=0x1FFE, len=4 -> read/write addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- Core never asserts done, TIMEOUT=16, len=2 -> ERROR after 16 cycles in START/RUN; sts_error=1, sts_count=0, no out_wen.
- cfg_abort during RUN of sample 1 (len=5) -> IDLE next cycle, one-cycle core_resetn low, sts_count=1, sts_done=0, sts_error=0.
- resetn low mid-WAIT_RD with RD_LAT=3 -> all outputs 0 and core_resetn=0 next cycle; a new cfg_start after release runs normally.

Source files
------------

// File: rtl/dfr_seq_pkg.sv
// Shared definitions for the DFR batch sequencer.
//   state_e    : sequencer FSM states
//   DefDataW   : default input word width; I is the upper half, Q the lower half
//   IHi..QLo   : I/Q slice bounds for the default word width
//   DefTimeout : default per-sample core timeout in cycles
//   half_w()   : I/Q half width for an arbitrary word width
package dfr_seq_pkg;

  localparam int unsigned DefDataW   = 32;
  localparam int unsigned DefTimeout = 4096;

  localparam int unsigned IHi = DefDataW - 1;
  localparam int unsigned ILo = DefDataW / 2;
  localparam int unsigned QHi = DefDataW / 2 - 1;
  localparam int unsigned QLo = 0;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StWaitRd,
    StCrst,
    StStart,
    StRun,
    StWrite,
    StDone,
    StError
  } state_e;

  function automatic int unsigned half_w(input int unsigned data_w);
    return data_w / 2;
  endfunction

endpackage

// File: rtl/dfr_seq_timeout.sv
// Loadable down-counter with an expire flag. Used by the sequencer both to
// wait out the input memory read latency and to bound the core run time.
//   clk, resetn : clock, synchronous active-low reset
//   load, value : load the counter with value (takes priority over dec)
//   dec         : decrement by one, stopping at zero
//   expired     : counter is zero
module dfr_seq_timeout #(
  parameter int unsigned W = 13
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/dfr_batch_seq.sv
// DFR batch sequencer: walks cfg_len samples of the input memory starting at
// cfg_base, runs each {I,Q} word through the DFR core over its start/busy/done
// handshake and writes each result to the output RAM at the sample's address.
// Addresses wrap modulo 2^ADDR_W. A per-sample core timeout ends the batch with
// sts_error; cfg_abort ends it silently.
//   cfg_*  : start/abort pulses, window base and length
//   sts_*  : busy, sticky done/error, completed-sample count
//   in_*   : input memory read port (data valid RD_LAT cycles after in_rd_en)
//   core_* : DFR core reset/handshake/sample/result
//   out_*  : output RAM write port
// Optional: define DFR_BATCH_SEQ_PERF_EN to add sts_cycles, a saturating count
// of busy cycles cleared on each accepted start.
module dfr_batch_seq
  import dfr_seq_pkg::*;
#(
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned OUT_W   = 26,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic [ADDR_W-1:0]     cfg_base,
  input  logic [ADDR_W:0]       cfg_len,
  output logic                  sts_busy,
  output logic                  sts_done,
  output logic                  sts_error,
  output logic [ADDR_W:0]       sts_count,
  output logic                  in_rd_en,
  output logic [ADDR_W-1:0]     in_addr,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  core_resetn,
  output logic                  core_start,
  input  logic                  core_busy,
  input  logic                  core_done,
  output logic [DATA_W/2-1:0]   core_i,
  output logic [DATA_W/2-1:0]   core_q,
  input  logic [OUT_W-1:0]      core_result,
  output logic                  out_wen,
  output logic [ADDR_W-1:0]     out_addr,
  output logic [OUT_W-1:0]      out_data
`ifdef DFR_BATCH_SEQ_PERF_EN
  ,
  output logic [31:0]           sts_cycles
`endif
);

  localparam int unsigned HalfW = half_w(DATA_W);
  localparam int unsigned CntW  = $clog2(TIMEOUT + RD_LAT) + 1;

  state_e            st;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   idx_q;
  logic [ADDR_W:0]   idx_nxt;
  logic [ADDR_W-1:0] cur_addr;

  logic            tmr_load;
  logic [CntW-1:0] tmr_val;
  logic            tmr_dec;
  logic            tmr_expired;

  assign idx_nxt   = idx_q + 1'b1;
  assign cur_addr  = base_q + idx_q[ADDR_W-1:0];
  assign sts_busy  = (st != StIdle);
  assign sts_count = idx_q;

  // The read-latency wait and the core timeout never overlap, so one counter
  // serves both: loaded on the cycle before each phase begins.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (st == StFetch) begin
      tmr_load = 1'b1;
      tmr_val  = CntW'(RD_LAT - 1);
    end else if (st == StCrst) begin
      tmr_load = 1'b1;
      tmr_val  = CntW'(TIMEOUT - 1);
    end
  end

  assign tmr_dec = (st == StWaitRd) || (st == StStart) || (st == StRun);

  dfr_seq_timeout #(
    .W(CntW)
  ) u_timeout (
    .clk    (clk),
    .resetn (resetn),
    .load   (tmr_load),
    .value  (tmr_val),
    .dec    (tmr_dec),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      st          <= StIdle;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      sts_done    <= 1'b0;
      sts_error   <= 1'b0;
      in_rd_en    <= 1'b0;
      in_addr     <= '0;
      core_resetn <= 1'b0;
      core_start  <= 1'b0;
      core_i      <= '0;
      core_q      <= '0;
      out_wen     <= 1'b0;
      out_addr    <= '0;
      out_data    <= '0;
    end else if (cfg_abort && (st != StIdle)) begin
      // Pulse the core reset for the first idle cycle; flags stay as they are.
      st          <= StIdle;
      in_rd_en    <= 1'b0;
      core_start  <= 1'b0;
      out_wen     <= 1'b0;
      core_resetn <= 1'b0;
    end else begin
      unique case (st)
        StIdle: begin
          core_resetn <= 1'b1;
          if (cfg_start) begin
            base_q    <= cfg_base;
            len_q     <= cfg_len;
            idx_q     <= '0;
            sts_done  <= 1'b0;
            sts_error <= 1'b0;
            if (cfg_len == '0) begin
              st <= StDone;
            end else begin
              st       <= StFetch;
              in_rd_en <= 1'b1;
              in_addr  <= cfg_base;
            end
          end
        end
        StFetch: begin
          in_rd_en <= 1'b0;
          st       <= StWaitRd;
        end
        StWaitRd: begin
          if (tmr_expired) begin
            core_i      <= in_data[DATA_W-1 -: HalfW];
            core_q      <= in_data[HalfW-1:0];
            core_resetn <= 1'b0;
            st          <= StCrst;
          end
        end
        StCrst: begin
          core_resetn <= 1'b1;
          core_start  <= 1'b1;
          st          <= StStart;
        end
        StStart, StRun: begin
          // A done seen while still in START counts as completion.
          if (core_done) begin
            core_start <= 1'b0;
            out_wen    <= 1'b1;
            out_addr   <= cur_addr;
            out_data   <= core_result;
            st         <= StWrite;
          end else if (tmr_expired) begin
            core_start  <= 1'b0;
            core_resetn <= 1'b0;
            st          <= StError;
          end else if ((st == StStart) && core_busy) begin
            core_start <= 1'b0;
            st         <= StRun;
          end
        end
        StWrite: begin
          out_wen <= 1'b0;
          idx_q   <= idx_nxt;
          if (idx_nxt == len_q) begin
            st <= StDone;
          end else begin
            st       <= StFetch;
            in_rd_en <= 1'b1;
            in_addr  <= base_q + idx_nxt[ADDR_W-1:0];
          end
        end
        StDone: begin
          sts_done <= 1'b1;
          st       <= StIdle;
        end
        StError: begin
          sts_error   <= 1'b1;
          core_resetn <= 1'b1;
          st          <= StIdle;
        end
        default: st <= StIdle;
      endcase
    end
  end

`ifdef DFR_BATCH_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sts_cycles <= '0;
    end else if (st == StIdle) begin
      if (cfg_start) begin
        sts_cycles <= '0;
      end
    end else if (sts_cycles != '1) begin
      sts_cycles <= sts_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dfr_batch_seq.sv
// Bench for dfr_batch_seq. Instance a: RD_LAT=1, TIMEOUT=16. Instance b:
// RD_LAT=3, TIMEOUT=16. A behavioural core answers done 10 cycles after it
// accepts start, and a pipelined memory returns a known word per address.
module tb_dfr_batch_seq;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 32;
  localparam int unsigned OW = 26;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rstn_a = 1'b0, rstn_b = 1'b0;
  logic          start_a = 1'b0, start_b = 1'b0;
  logic          cfg_abort = 1'b0;
  logic [AW-1:0] cfg_base = '0;
  logic [AW:0]   cfg_len = '0;
  logic          core_hang = 1'b0;

  logic          sts_busy [2], sts_done [2], sts_error [2];
  logic [AW:0]   sts_count [2];
  logic          in_rd_en [2];
  logic [AW-1:0] in_addr [2];
  logic          core_resetn [2], core_start [2];
  logic [DW/2-1:0] core_i [2], core_q [2];
  logic          out_wen [2];
  logic [AW-1:0] out_addr [2];
  logic [OW-1:0] out_data [2];

  logic          core_busy [2] = '{1'b0, 1'b0};
  logic          core_done [2] = '{1'b0, 1'b0};
  logic [OW-1:0] core_result [2] = '{'0, '0};
  logic          running [2] = '{1'b0, 1'b0};
  int            ccnt [2] = '{0, 0};
  logic [DW-1:0] pipe [2][4];

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {16'(a) ^ 16'h5A00, 16'(a) * 16'd7 + 16'd3};
  endfunction

  function automatic logic [OW-1:0] model_res(input logic [15:0] i, input logic [15:0] q);
    return {i[9:0], q};
  endfunction

  function automatic logic [OW-1:0] exp_res(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    w = mem_word(a);
    return model_res(w[31:16], w[15:0]);
  endfunction

  dfr_batch_seq #(.ADDR_W(AW), .DATA_W(DW), .OUT_W(OW), .RD_LAT(1), .TIMEOUT(TO)) u_dut_a (
    .clk(clk), .resetn(rstn_a), .cfg_start(start_a), .cfg_abort(cfg_abort),
    .cfg_base(cfg_base), .cfg_len(cfg_len), .sts_busy(sts_busy[0]), .sts_done(sts_done[0]),
    .sts_error(sts_error[0]), .sts_count(sts_count[0]), .in_rd_en(in_rd_en[0]),
    .in_addr(in_addr[0]), .in_data(pipe[0][0]), .core_resetn(core_resetn[0]),
    .core_start(core_start[0]), .core_busy(core_busy[0]), .core_done(core_done[0]),
    .core_i(core_i[0]), .core_q(core_q[0]), .core_result(core_result[0]),
    .out_wen(out_wen[0]), .out_addr(out_addr[0]), .out_data(out_data[0])
`ifdef DFR_BATCH_SEQ_PERF_EN
    , .sts_cycles()
`endif
  );

  dfr_batch_seq #(.ADDR_W(AW), .DATA_W(DW), .OUT_W(OW), .RD_LAT(3), .TIMEOUT(TO)) u_dut_b (
    .clk(clk), .resetn(rstn_b), .cfg_start(start_b), .cfg_abort(cfg_abort),
    .cfg_base(cfg_base), .cfg_len(cfg_len), .sts_busy(sts_busy[1]), .sts_done(sts_done[1]),
    .sts_error(sts_error[1]), .sts_count(sts_count[1]), .in_rd_en(in_rd_en[1]),
    .in_addr(in_addr[1]), .in_data(pipe[1][2]), .core_resetn(core_resetn[1]),
    .core_start(core_start[1]), .core_busy(core_busy[1]), .core_done(core_done[1]),
    .core_i(core_i[1]), .core_q(core_q[1]), .core_result(core_result[1]),
    .out_wen(out_wen[1]), .out_addr(out_addr[1]), .out_data(out_data[1])
`ifdef DFR_BATCH_SEQ_PERF_EN
    , .sts_cycles()
`endif
  );

  // Memory: a word launched on a read strobe moves one stage per cycle.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      pipe[g][0] <= in_rd_en[g] ? mem_word(in_addr[g]) : 32'hDEAD_BEEF;
      for (int k = 1; k < 4; k++) pipe[g][k] <= pipe[g][k-1];
    end
  end

  // Core: busy after accepting start, one-cycle done 10 cycles after that.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      core_done[g] <= 1'b0;
      if (!core_resetn[g]) begin
        running[g]   <= 1'b0;
        core_busy[g] <= 1'b0;
      end else if (running[g]) begin
        if (!core_hang && ccnt[g] == 9) begin
          core_done[g]   <= 1'b1;
          core_busy[g]   <= 1'b0;
          running[g]     <= 1'b0;
          core_result[g] <= model_res(core_i[g], core_q[g]);
        end else begin
          ccnt[g] <= ccnt[g] + 1;
        end
      end else if (core_start[g]) begin
        running[g]   <= 1'b1;
        core_busy[g] <= 1'b1;
        ccnt[g]      <= 1;
      end
    end
  end

  logic [AW-1:0] rd_addr_q [$];
  int            rd_cyc_q [$];
  logic [AW-1:0] wr_addr_q [$];
  logic [OW-1:0] wr_data_q [$];
  logic [AW-1:0] wrb_addr_q [$];
  logic [OW-1:0] wrb_data_q [$];
  int            start_cnt = 0;
  logic          start_prev = 1'b0;

  always @(negedge clk) begin
    if (in_rd_en[0]) begin
      rd_addr_q.push_back(in_addr[0]);
      rd_cyc_q.push_back(cyc);
    end
    if (out_wen[0]) begin
      wr_addr_q.push_back(out_addr[0]);
      wr_data_q.push_back(out_data[0]);
    end
    if (out_wen[1]) begin
      wrb_addr_q.push_back(out_addr[1]);
      wrb_data_q.push_back(out_data[1]);
    end
    if (core_start[0] && !start_prev) start_cnt = start_cnt + 1;
    start_prev = core_start[0];
  end

  task automatic run_start(input int g, input logic [AW-1:0] b, input logic [AW:0] l);
    @(negedge clk);
    cfg_base = b;
    cfg_len  = l;
    if (g == 0) start_a = 1'b1;
    else        start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_idle(input int g, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!sts_busy[g]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({sts_busy[0], sts_done[0], sts_error[0], in_rd_en[0], core_resetn[0], core_start[0],
         out_wen[0]} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 0", {sts_busy[0], sts_done[0], sts_error[0],
               in_rd_en[0], core_resetn[0], core_start[0], out_wen[0]});
    end
    n_cmp++;
    if ({sts_count[0], in_addr[0], out_addr[0], out_data[0]} !== '0) begin
      n_err++;
      $display("FAIL reset_values: got %0h/%0h/%0h/%0h want 0", sts_count[0], in_addr[0],
               out_addr[0], out_data[0]);
    end
    rstn_a = 1'b1;
    rstn_b = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (core_resetn[0] !== 1'b1 || sts_busy[0] !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got rstn=%b busy=%b want 1/0", core_resetn[0], sts_busy[0]);
    end
  endtask

  task automatic test_basic();
    int r0, w0;
    bit ok;
    r0 = rd_addr_q.size();
    w0 = wr_addr_q.size();
    run_start(0, '0, 3);
    wait_idle(0, 200, ok);
    @(negedge clk);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL basic_finish: got busy want idle"); end
    n_cmp++;
    if (rd_addr_q.size() - r0 != 3 || wr_addr_q.size() - w0 != 3) begin
      n_err++;
      $display("FAIL basic_counts: got rd=%0d wr=%0d want 3/3", rd_addr_q.size() - r0,
               wr_addr_q.size() - w0);
    end
    for (int i = 0; i < 3; i++) begin
      logic [AW-1:0] a;
      a = AW'(i);
      n_cmp++;
      if (rd_addr_q[r0+i] !== a || wr_addr_q[w0+i] !== a) begin
        n_err++;
        $display("FAIL basic_addr%0d: got rd=%0h wr=%0h want %0h", i, rd_addr_q[r0+i],
                 wr_addr_q[w0+i], a);
      end
      n_cmp++;
      if (wr_data_q[w0+i] !== exp_res(a)) begin
        n_err++;
        $display("FAIL basic_data%0d: got %0h want %0h", i, wr_data_q[w0+i], exp_res(a));
      end
    end
    for (int i = 1; i < 3; i++) begin
      n_cmp++;
      if (rd_cyc_q[r0+i] - rd_cyc_q[r0+i-1] != 15) begin
        n_err++;
        $display("FAIL basic_period%0d: got %0d want 15", i, rd_cyc_q[r0+i] - rd_cyc_q[r0+i-1]);
      end
    end
    n_cmp++;
    if (sts_done[0] !== 1'b1 || sts_error[0] !== 1'b0 || sts_count[0] !== 14'd3) begin
      n_err++;
      $display("FAIL basic_status: got done=%b err=%b cnt=%0d want 1/0/3", sts_done[0],
               sts_error[0], sts_count[0]);
    end
  endtask

  task automatic test_len_zero();
    int r0, s0;
    r0 = rd_addr_q.size();
    s0 = start_cnt;
    run_start(0, 13'h40, '0);
    n_cmp++;
    if (sts_done[0] !== 1'b0 || sts_busy[0] !== 1'b1) begin
      n_err++;
      $display("FAIL len0_first: got done=%b busy=%b want 0/1", sts_done[0], sts_busy[0]);
    end
    @(negedge clk);
    n_cmp++;
    if (sts_done[0] !== 1'b1 || sts_busy[0] !== 1'b0 || sts_count[0] !== '0) begin
      n_err++;
      $display("FAIL len0_done: got done=%b busy=%b cnt=%0d want 1/0/0", sts_done[0],
               sts_busy[0], sts_count[0]);
    end
    @(negedge clk);
    n_cmp++;
    if (rd_addr_q.size() != r0 || start_cnt != s0) begin
      n_err++;
      $display("FAIL len0_quiet: got rd=%0d starts=%0d want 0/0", rd_addr_q.size() - r0,
               start_cnt - s0);
    end
  endtask

  task automatic test_wrap();
    int r0, w0;
    bit ok;
    logic [AW-1:0] exp_a [4];
    exp_a = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
    r0 = rd_addr_q.size();
    w0 = wr_addr_q.size();
    run_start(0, 13'h1FFE, 4);
    wait_idle(0, 300, ok);
    @(negedge clk);
    n_cmp++;
    if (ok !== 1'b1 || sts_count[0] !== 14'd4 || sts_done[0] !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_status: got ok=%b cnt=%0d done=%b want 1/4/1", ok, sts_count[0],
               sts_done[0]);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rd_addr_q[r0+i] !== exp_a[i] || wr_addr_q[w0+i] !== exp_a[i] ||
          wr_data_q[w0+i] !== exp_res(exp_a[i])) begin
        n_err++;
        $display("FAIL wrap_%0d: got rd=%0h wr=%0h data=%0h want %0h/%0h/%0h", i,
                 rd_addr_q[r0+i], wr_addr_q[w0+i], wr_data_q[w0+i], exp_a[i], exp_a[i],
                 exp_res(exp_a[i]));
      end
    end
  endtask

  task automatic test_timeout();
    int w0, t_s, t_e;
    bit ok;
    w0 = wr_addr_q.size();
    t_s = -1;
    t_e = -1;
    ok = 1'b0;
    core_hang = 1'b1;
    run_start(0, 13'h10, 2);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (core_start[0] && t_s < 0) t_s = cyc;
      if (!core_resetn[0] && t_s >= 0 && t_e < 0) t_e = cyc;
      if (!sts_busy[0]) begin
        ok = 1'b1;
        break;
      end
    end
    core_hang = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ok !== 1'b1 || t_s < 0 || t_e - t_s != 16) begin
      n_err++;
      $display("FAIL timeout_len: got ok=%b cycles=%0d want 1/16", ok, t_e - t_s);
    end
    n_cmp++;
    if (sts_error[0] !== 1'b1 || sts_done[0] !== 1'b0 || sts_count[0] !== '0) begin
      n_err++;
      $display("FAIL timeout_status: got err=%b done=%b cnt=%0d want 1/0/0", sts_error[0],
               sts_done[0], sts_count[0]);
    end
    n_cmp++;
    if (wr_addr_q.size() != w0) begin
      n_err++;
      $display("FAIL timeout_nowrite: got %0d writes want 0", wr_addr_q.size() - w0);
    end
  endtask

  task automatic test_abort();
    int w0;
    bit found;
    w0 = wr_addr_q.size();
    found = 1'b0;
    run_start(0, 13'h20, 5);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_wen[0]) begin
        found = 1'b1;
        break;
      end
    end
    // Cycles after the write: FETCH, WAIT_RD, CRST, START x2, then RUN.
    repeat (7) @(negedge clk);
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_abort = 1'b0;
    n_cmp++;
    if (found !== 1'b1 || sts_busy[0] !== 1'b0 || core_resetn[0] !== 1'b0 ||
        out_wen[0] !== 1'b0) begin
      n_err++;
      $display("FAIL abort_idle: got found=%b busy=%b rstn=%b wen=%b want 1/0/0/0", found,
               sts_busy[0], core_resetn[0], out_wen[0]);
    end
    @(negedge clk);
    n_cmp++;
    if (core_resetn[0] !== 1'b1) begin
      n_err++;
      $display("FAIL abort_rst_pulse: got %b want 1", core_resetn[0]);
    end
    repeat (30) @(negedge clk);
    n_cmp++;
    if (sts_count[0] !== 14'd1 || sts_done[0] !== 1'b0 || sts_error[0] !== 1'b0 ||
        wr_addr_q.size() - w0 != 1 || sts_busy[0] !== 1'b0) begin
      n_err++;
      $display("FAIL abort_status: got cnt=%0d done=%b err=%b wr=%0d busy=%b want 1/0/0/1/0",
               sts_count[0], sts_done[0], sts_error[0], wr_addr_q.size() - w0, sts_busy[0]);
    end
  endtask

  task automatic test_back_to_back();
    int w0;
    bit ok;
    w0 = wr_addr_q.size();
    @(negedge clk);
    cfg_base  = 13'h5;
    cfg_len   = 1;
    start_a   = 1'b1;
    cfg_abort = 1'b1;
    @(negedge clk);
    start_a   = 1'b0;
    cfg_abort = 1'b0;
    n_cmp++;
    if (sts_busy[0] !== 1'b1) begin
      n_err++;
      $display("FAIL start_beats_abort: got busy=%b want 1", sts_busy[0]);
    end
    repeat (3) @(negedge clk);
    cfg_base = 13'h100;
    cfg_len  = 3;
    start_a  = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_idle(0, 100, ok);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (ok !== 1'b1 || sts_count[0] !== 14'd1 || sts_done[0] !== 1'b1 ||
        wr_addr_q.size() - w0 != 1 || sts_busy[0] !== 1'b0) begin
      n_err++;
      $display("FAIL busy_start_dropped: got ok=%b cnt=%0d done=%b wr=%0d busy=%b want 1/1/1/1/0",
               ok, sts_count[0], sts_done[0], wr_addr_q.size() - w0, sts_busy[0]);
    end
    n_cmp++;
    if (wr_addr_q[w0] !== 13'h5 || wr_data_q[w0] !== exp_res(13'h5)) begin
      n_err++;
      $display("FAIL single_write: got %0h/%0h want 5/%0h", wr_addr_q[w0], wr_data_q[w0],
               exp_res(13'h5));
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    bit ok;
    run_start(1, 13'h4, 2);
    n_cmp++;
    if (in_rd_en[1] !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_fetch: got %b want 1", in_rd_en[1]);
    end
    @(negedge clk);
    rstn_b = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({sts_busy[1], sts_done[1], sts_error[1], in_rd_en[1], core_resetn[1], core_start[1],
         out_wen[1]} !== 7'b0 || {sts_count[1], in_addr[1], core_i[1], core_q[1], out_addr[1],
         out_data[1]} !== '0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got busy=%b rstn=%b addr=%0h cnt=%0d want all 0",
               sts_busy[1], core_resetn[1], in_addr[1], sts_count[1]);
    end
    @(negedge clk);
    rstn_b = 1'b1;
    @(negedge clk);
    w0 = wrb_addr_q.size();
    run_start(1, 13'h4, 2);
    wait_idle(1, 200, ok);
    @(negedge clk);
    n_cmp++;
    if (ok !== 1'b1 || sts_done[1] !== 1'b1 || sts_count[1] !== 14'd2 ||
        wrb_addr_q.size() - w0 != 2) begin
      n_err++;
      $display("FAIL rst_mid_rerun: got ok=%b done=%b cnt=%0d wr=%0d want 1/1/2/2", ok,
               sts_done[1], sts_count[1], wrb_addr_q.size() - w0);
    end
    for (int i = 0; i < 2; i++) begin
      logic [AW-1:0] a;
      a = AW'(4 + i);
      n_cmp++;
      if (wrb_addr_q[w0+i] !== a || wrb_data_q[w0+i] !== exp_res(a)) begin
        n_err++;
        $display("FAIL rst_mid_write%0d: got %0h/%0h want %0h/%0h", i, wrb_addr_q[w0+i],
                 wrb_data_q[w0+i], a, exp_res(a));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_wrap();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
